// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // WIDTH must split into STAGES equal, non-empty slices.
  function automatic bit stages_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit ripple adder; one full-adder cell per bit, exposing
// the carry into its top bit so the final stage can derive signed overflow.
module addsub_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);

  logic cy;

  always_comb begin
    cy       = cin;
    c_msb_in = cin;
    sum      = '0;
    for (int i = 0; i < SW; i++) begin
      c_msb_in = cy;
      sum[i]   = a[i] ^ b[i] ^ cy;
      cy       = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: one SW-bit slice per stage, carry handed
// stage to stage, per-stage ready so bubbles collapse under backpressure.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_t              in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (!stages_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: STAGES must be 1..WIDTH and divide WIDTH");
  end

  // SUB becomes A + ~B + 1; in_cin only matters for ADD.
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

  always_comb begin
    eff_b   = (in_op == OP_SUB) ? ~in_b : in_b;
    eff_cin = (in_op == OP_SUB) ? 1'b1 : in_cin;
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;

  always_comb begin
    rdy[LAST] = out_ready || !vld[LAST];
    for (int k = STAGES - 2; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = (k + 1) * SW;  // result bits resolved after this stage
    localparam int PW = WIDTH - RW;    // operand bits still to be consumed

    logic          up_v;
    logic [SW-1:0] sl_a, sl_b, sl_sum;
    logic          sl_c_in, sl_cout, sl_cmsb;
    logic [RW-1:0] s_new, s_q, s_d;
    logic          v_q, v_d, c_q, c_d;

    if (k == 0) begin : g_up
      assign up_v    = in_valid;
      assign sl_a    = in_a[SW-1:0];
      assign sl_b    = eff_b[SW-1:0];
      assign sl_c_in = eff_cin;
      assign s_new   = sl_sum;
    end else begin : g_up
      assign up_v    = vld[k-1];
      assign sl_a    = g_st[k-1].g_pend.a_q[SW-1:0];
      assign sl_b    = g_st[k-1].g_pend.b_q[SW-1:0];
      assign sl_c_in = g_st[k-1].c_q;
      assign s_new   = {sl_sum, g_st[k-1].s_q};
    end

    addsub_slice #(.SW(SW)) u_slice (
      .a        (sl_a),
      .b        (sl_b),
      .cin      (sl_c_in),
      .sum      (sl_sum),
      .cout     (sl_cout),
      .c_msb_in (sl_cmsb)
    );

    // Unconsumed operand bits ride along right-justified.
    if (PW > 0) begin : g_pend
      logic [PW-1:0] a_q, a_d, b_q, b_d, a_new, b_new;

      if (k == 0) begin : g_src
        assign a_new = in_a[WIDTH-1:SW];
        assign b_new = eff_b[WIDTH-1:SW];
      end else begin : g_src
        assign a_new = g_st[k-1].g_pend.a_q[PW+SW-1:SW];
        assign b_new = g_st[k-1].g_pend.b_q[PW+SW-1:SW];
      end

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (rdy[k] && up_v) begin
          a_d = a_new;
          b_d = b_new;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    always_comb begin
      v_d = v_q;
      s_d = s_q;
      c_d = c_q;
      if (rdy[k]) v_d = up_v;
      if (rdy[k] && up_v) begin
        s_d = s_new;
        c_d = sl_cout;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else begin
        v_q <= v_d;
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    assign vld[k] = v_q;
  end

  logic cm_q, cm_d;

  always_comb begin
    cm_d = cm_q;
    if (rdy[LAST] && g_st[LAST].up_v) cm_d = g_st[LAST].sl_cmsb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cm_q <= 1'b0;
    else       cm_q <= cm_d;
  end

  assign out_valid = vld[LAST];
  assign out_sum   = g_st[LAST].s_q;
  assign out_cout  = g_st[LAST].c_q;
  assign out_ovf   = cm_q ^ g_st[LAST].c_q;
  assign out_zero  = ~|out_sum;

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; next generation of the team's fixed 32-bit ripple adder.
- Splits a WIDTH-bit operation into STAGES equal slices, one per register stage, with the carry forwarded between stages.
- Valid/ready handshakes on input and output, and status flags.
- Sits between operand-issue logic and the ALU result/writeback path.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, number of pipeline stages. Legal range 1..WIDTH; WIDTH mod STAGES must be 0; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op present
- in_ready  output  1  block accepts input this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  op_t  ADD or SUB
- in_cin  input  1  carry-in, used for ADD only
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB (SUB: 1 means no borrow)
- out_ovf  output  1  signed overflow
- out_zero  output  1  out_sum == 0

Behaviour:
- Transfer rules:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- Operand preparation at acceptance:
  - SUB: effective B = ~in_b and carry-in = 1. in_cin is ignored.
  - ADD: effective B = in_b and carry-in = in_cin.
- Slicing: SW = WIDTH/STAGES. Stage k (1..STAGES) computes bits [k*SW-1:(k-1)*SW] from:
  - the registered unconsumed operand bits, and
  - the carry registered by stage k-1 (stage 1 uses the prepared carry-in).
  - Lower result bits and remaining upper operand bits travel with the token.
- Stage register contents: valid bit v[k], partial sum, carry, pending operand bits. Stage STAGES additionally holds the carry into the MSB for the overflow flag.
- Flow control: per-stage ready with bubble collapse.
  - rdy[STAGES] = out_ready || !v[STAGES].
  - rdy[k] = !v[k] || rdy[k+1] for k < STAGES.
  - in_ready = rdy[1].
  - Stage k loads from stage k-1 (stage 1 loads from input) when rdy[k]. v[k] takes the upstream valid/transfer bit.
- Latency: out_valid rises STAGES cycles after the accepting edge when there is no backpressure. Throughput is 1 op/cycle.
- Backpressure:
  - While out_valid && !out_ready, all outputs hold stable.
  - Upstream stages continue filling bubbles. in_ready falls only when all STAGES registers are valid.
  - Capacity is exactly STAGES ops. No op is dropped or duplicated, and order is preserved.
- Flags, valid when out_valid:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = ~|out_sum.
- Wrap-around: results are modulo 2^WIDTH; the overflow/carry indication is carried only by the flags.
- Reset (asynchronous, any time including mid-operation):
  - All v[k] are cleared and data registers go to 0.
  - out_valid = 0; out_sum, out_cout, out_ovf = 0; out_zero = 1 (derived from sum 0).
  - in_ready = 1 from the first cycle after reset deasserts.
  - In-flight ops are discarded.
- Simultaneous input accept and output drain with a full pipe: allowed. The pipe shifts and stays full.
- STAGES = 1: single register stage, latency 1, same handshake.
- Outputs are driven directly from the stage-STAGES registers; out_zero is combinational from the registered sum.

Decomposition:
- Package adder_pkg:
  - op_t enum {OP_ADD = 1'b0, OP_SUB = 1'b1}.
  - Parameter-legality check helper.
- Sub-module addsub_slice: combinational SW-bit ripple adder built from full-adder cells. Inputs a, b, cin; outputs sum, cout, and carry into its top bit (c_msb_in).
- One instance per stage, created by a generate loop.

Test Plan (WIDTH=32, STAGES=4 unless stated):
1. ADD 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 -> out_valid exactly 4 cycles later; sum 0x00000000, cout=1, ovf=0, zero=1.
2. ADD 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, cout=0, ovf=1. ADD 0x00000010 + 0x00000020, cin=1 -> sum 0x00000031.
3. SUB 5 - 7 -> 0xFFFFFFFE, cout=0, ovf=0. SUB 0x80000000 - 1 -> 0x7FFFFFFF, cout=1, ovf=1. SUB 9 - 9 with cin=0 -> 0, cout=1, zero=1 (cin ignored).
4. Issue 8 back-to-back ops with in_valid=1; hold out_ready=0 from the first out_valid -> exactly 4 accepted, then in_ready=0. Release out_ready -> results drain in issue order, 1/cycle, with none lost.
5. Bubble collapse: one op, then 3 idle cycles, then one op, with out_ready=0 -> both ops resident and in_ready=1. The first result holds stable until out_ready=1.
6. Assert reset with 3 ops in flight -> out_valid=0 immediately (asynchronous); after release, in_ready=1 and no stale result appears. Repeat test 1 with STAGES=1 (latency 1) and STAGES=32.
